bitonic_out_serializer: RTL and testbench
=========================================

# bitonic_out_serializer

Output-side reader for the bitonic sorting network. Captures one sorted N-word vector, as produced by the sorter stages, through a valid/ready handshake. Streams the words out one W-bit word per beat with valid/ready flow control, in ascending or descending word-index order. Sits after the final sorter stage and feeds narrow downstream consumers.

## Interface
Parameters:
- W, 16, word width in bits
- N, 4, words per vector; power of two, ≥2

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  vector present on in_data
- in_ready  out  1  serializer can accept a vector this cycle
- in_data  in  N*W  word i at bits [W*i+W-1 : W*i]
- in_dir  in  1  emit order, sampled with the vector: 0 = word 0 first, 1 = word N-1 first
- out_valid  out  1  out_data holds a valid word
- out_ready  in  1  downstream accepts the word this cycle
- out_data  out  W  current word
- out_idx  out  log2(N)  word index of out_data within its vector
- out_last  out  1  current word is the final word of its vector

## Operation
- Vector accept: in_valid & in_ready at a rising edge. Word beat: out_valid & out_ready at a rising edge.
- FSM states:
  - IDLE: out_valid=0; in_ready=1.
  - DRAIN: out_valid=1.
- IDLE → DRAIN on a vector accept:
  - load the work register from in_data;
  - latch in_dir;
  - set idx to 0 (dir=0) or N-1 (dir=1).
- In DRAIN:
  - out_data = word[idx] of the work register;
  - out_idx = idx;
  - out_last = 1 when idx==N-1 (dir=0) or idx==0 (dir=1).
- A word beat with out_last=0 steps idx by +1 (dir=0) or -1 (dir=1). idx never wraps.
- A word beat with out_last=1 ends the vector:
  - if a next vector is available, DRAIN restarts on it (see Configuration);
  - otherwise the FSM goes to IDLE.
- Stall: while out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
- Input data is used only on the accept edge. Changes to in_data at other times have no effect.
- Reset:
  - clears the FSM to IDLE, the work register to 0 and idx to 0;
  - a vector being drained is discarded, with no further beats.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0.
  - Exception: in_ready=0 while rst is asserted.

## Timing
- Vector accepted at edge k → first word has out_valid=1 in the cycle after edge k. Latency is 1 cycle.
- out_ready held high: one word per cycle, N beats per vector.
- out_valid never depends combinationally on out_ready.
- in_ready depends only on registered state, with no combinational path from out_ready or in_valid.
- Single-buffer throughput: N+1 cycles per vector (one IDLE cycle between vectors).
- Double-buffer throughput: N cycles per vector, back-to-back.

## Configuration
- Macro: BITONIC_SER_DBUF_EN.
- Defined: adds a one-vector holding register with its own latched dir.
  - in_ready = !hold_full, in both IDLE and DRAIN.
  - An accept in IDLE loads the work register directly. An accept in DRAIN loads the holding register.
  - On the out_last beat with hold_full=1, the holding register moves to the work register, idx is reloaded per the held dir, and the FSM stays in DRAIN. The next vector's first word appears in the following cycle with no gap.
  - An accept on the same edge as that transfer is legal only if hold_full was 0. Since in_ready=!hold_full, no accept and transfer can collide.
- Undefined: no holding register; in_ready=1 only in IDLE.

## Test plan
- W=16, N=4. Accept in_data=0x0004_0003_0002_0001 with in_dir=0 and out_ready=1 → beats 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles; out_idx 0..3; out_last only on 0x0004; IDLE next cycle.
- Same vector, in_dir=1 → beats 0x0004, 0x0003, 0x0002, 0x0001; out_idx 3,2,1,0; out_last on 0x0001.
- out_ready toggled 1,0,0,1,1,0,1 → exactly 4 beats delivered, data stable through stalls, no word skipped or repeated.
- in_valid held high with two vectors, out_ready=1, macro off → in_ready low for 4 cycles and the second vector starts after one idle cycle. Macro on → the 8 beats are contiguous.
- rst asserted during the 2nd beat → the next cycle shows out_valid=0, in_ready=1, out_idx=0; a new vector drains from its first word.

Source files
------------

// File: rtl/bitonic_out_serializer.sv
// bitonic_out_serializer
// Captures one sorted N-word vector through a valid/ready handshake and
// streams it out one W-bit word per beat, ascending or descending by word
// index as selected by in_dir at capture time.
// Optional feature macro: BITONIC_SER_DBUF_EN adds a one-vector holding
// register so a second vector can be accepted while the first drains,
// giving back-to-back vectors with no idle cycle.
module bitonic_out_serializer #(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*W-1:0]         in_data,
    input  logic                   in_dir,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_data,
    output logic [$clog2(N)-1:0]   out_idx,
    output logic                   out_last
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N*W-1:0]     work_q, work_d;
    logic               dir_q, dir_d;
    logic [IW-1:0]      idx_q, idx_d;

`ifdef BITONIC_SER_DBUF_EN
    logic [N*W-1:0]     hold_q, hold_d;
    logic               hold_dir_q, hold_dir_d;
    logic               hold_full_q, hold_full_d;
`endif

    logic               accept;
    logic               beat;
    logic               last_word;
    logic [W-1:0]       work_words [N];

    // First index of a vector depends only on its emit direction.
    function automatic logic [IW-1:0] start_idx(input logic dir);
        return dir ? IDX_MAX : '0;
    endfunction

    // Slice the work register into addressable words.
    for (genvar gi = 0; gi < N; gi++) begin : g_words
        assign work_words[gi] = work_q[gi*W +: W];
    end

    // Handshake and output decode; everything here is from registered state
    // except in_ready's forced-low during reset.
    always_comb begin
        out_valid = (state_q == DRAIN);
        last_word = dir_q ? (idx_q == '0) : (idx_q == IDX_MAX);
        out_last  = out_valid & last_word;
        out_data  = work_words[idx_q];
        out_idx   = idx_q;
`ifdef BITONIC_SER_DBUF_EN
        in_ready  = !rst && !hold_full_q;
`else
        in_ready  = !rst && (state_q == IDLE);
`endif
        accept    = in_valid & in_ready;
        beat      = out_valid & out_ready;
    end

    // Next-state logic: capture, step the word index, and end/restart vectors.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dir_d   = dir_q;
        idx_d   = idx_q;
`ifdef BITONIC_SER_DBUF_EN
        hold_d      = hold_q;
        hold_dir_d  = hold_dir_q;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = in_data;
                    dir_d   = in_dir;
                    idx_d   = start_idx(in_dir);
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
`ifdef BITONIC_SER_DBUF_EN
                // A vector arriving mid-drain parks in the holding register,
                // unless the current vector ends on this very edge, in which
                // case it goes straight to the work register below.
                if (accept && !(beat && last_word)) begin
                    hold_d      = in_data;
                    hold_dir_d  = in_dir;
                    hold_full_d = 1'b1;
                end
`endif
                if (beat) begin
                    if (!last_word) begin
                        idx_d = dir_q ? (idx_q - 1'b1) : (idx_q + 1'b1);
                    end else begin
`ifdef BITONIC_SER_DBUF_EN
                        if (hold_full_q) begin
                            work_d      = hold_q;
                            dir_d       = hold_dir_q;
                            idx_d       = start_idx(hold_dir_q);
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            work_d = in_data;
                            dir_d  = in_dir;
                            idx_d  = start_idx(in_dir);
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset; a draining vector is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
`ifdef BITONIC_SER_DBUF_EN
            hold_q      <= '0;
            hold_dir_q  <= 1'b0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dir_q   <= dir_d;
            idx_q   <= idx_d;
`ifdef BITONIC_SER_DBUF_EN
            hold_q      <= hold_d;
            hold_dir_q  <= hold_dir_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

endmodule

// File: tb/tb_bitonic_out_serializer.sv
// Directed testbench for bitonic_out_serializer (W=16, N=4).
// Drives and samples 1 ns after each rising edge.
module tb_bitonic_out_serializer;

    localparam int W = 16;
    localparam int N = 4;

`ifdef BITONIC_SER_DBUF_EN
    localparam bit DBUF = 1'b1;
`else
    localparam bit DBUF = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           in_dir;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_idx;
    logic           out_last;

    int checks = 0;
    int errors = 0;

    bitonic_out_serializer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        logic [3:0] pat;
        logic [6:0] rdy_pat;
        int         beats;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;

        // Reset behaviour
        tick();
        tick();
        chk("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_out_data", {16'b0, out_data}, 32'h0);
        chk("reset_out_idx", {30'b0, out_idx}, 32'd0);
        chk("reset_out_last", {31'b0, out_last}, 32'd0);

        // Ascending drain, out_ready held high
        in_valid = 1'b1; in_data = 64'h0004_0003_0002_0001; in_dir = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("asc_valid%0d", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("asc_data%0d", i), {16'b0, out_data}, 32'(i + 1));
            chk($sformatf("asc_idx%0d", i), {30'b0, out_idx}, 32'(i));
            chk($sformatf("asc_last%0d", i), {31'b0, out_last}, 32'(i == 3));
            $display("asc beat %0d: data=%04h idx=%0d last=%0b", i, out_data, out_idx, out_last);
            tick();
        end
        chk("asc_idle_valid", {31'b0, out_valid}, 32'd0);
        chk("asc_idle_ready", {31'b0, in_ready}, 32'd1);

        // Descending drain
        in_valid = 1'b1; in_data = 64'h0004_0003_0002_0001; in_dir = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dsc_data%0d", i), {16'b0, out_data}, 32'(4 - i));
            chk($sformatf("dsc_idx%0d", i), {30'b0, out_idx}, 32'(3 - i));
            chk($sformatf("dsc_last%0d", i), {31'b0, out_last}, 32'(i == 3));
            $display("dsc beat %0d: data=%04h idx=%0d last=%0b", i, out_data, out_idx, out_last);
            tick();
        end
        chk("dsc_idle_valid", {31'b0, out_valid}, 32'd0);

        // Back-pressure: out_ready pattern 1,0,0,1,1,0,1 delivers exactly 4 beats
        rdy_pat = 7'b1011001; // bit k = out_ready in cycle k
        in_valid = 1'b1; in_data = 64'h4444_3333_2222_1111; in_dir = 1'b0;
        tick();
        in_valid = 1'b0;
        beats = 0;
        for (int k = 0; k < 7; k++) begin
            out_ready = rdy_pat[k];
            chk($sformatf("stall_valid%0d", k), {31'b0, out_valid}, 32'd1);
            chk($sformatf("stall_data%0d", k), {16'b0, out_data}, 32'h1111 * 32'(beats + 1));
            chk($sformatf("stall_idx%0d", k), {30'b0, out_idx}, 32'(beats));
            chk($sformatf("stall_last%0d", k), {31'b0, out_last}, 32'(beats == 3));
            $display("stall cycle %0d: ready=%0b data=%04h idx=%0d", k, out_ready, out_data, out_idx);
            tick();
            if (rdy_pat[k]) beats++;
        end
        chk("stall_done_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;

        // Two vectors with in_valid held high; in_data changes mid-drain
        in_valid = 1'b1; in_data = 64'ha003_a002_a001_a000; in_dir = 1'b0;
        tick();
        in_data = 64'hb003_b002_b001_b000;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("two_a_data%0d", i), {16'b0, out_data}, 32'ha000 + 32'(i));
            chk($sformatf("two_a_ready%0d", i), {31'b0, in_ready}, 32'(DBUF && i == 0));
            $display("two A beat %0d: data=%04h in_ready=%0b", i, out_data, in_ready);
            tick();
            if (DBUF && i == 0) in_valid = 1'b0;
        end
`ifndef BITONIC_SER_DBUF_EN
        chk("two_gap_valid", {31'b0, out_valid}, 32'd0);
        chk("two_gap_ready", {31'b0, in_ready}, 32'd1);
        tick();
`endif
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("two_b_valid%0d", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("two_b_data%0d", i), {16'b0, out_data}, 32'hb000 + 32'(i));
            $display("two B beat %0d: data=%04h", i, out_data);
            tick();
        end
        chk("two_end_valid", {31'b0, out_valid}, 32'd0);

        // Reset during the second beat
        in_valid = 1'b1; in_data = 64'h0004_0003_0002_0001; in_dir = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rstmid_beat1", {16'b0, out_data}, 32'h1);
        tick();
        chk("rstmid_beat2", {16'b0, out_data}, 32'h2);
        rst = 1'b1;
        #1;
        chk("rstmid_in_ready_low", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rstmid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstmid_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rstmid_out_idx", {30'b0, out_idx}, 32'd0);
        chk("rstmid_out_data", {16'b0, out_data}, 32'h0);
        $display("after reset: valid=%0b in_ready=%0b idx=%0d", out_valid, in_ready, out_idx);
        in_valid = 1'b1; in_data = 64'h4444_3333_2222_1111; in_dir = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pat = 4'(4 - i);
            chk($sformatf("post_data%0d", i), {16'b0, out_data}, 32'h1111 * 32'(pat));
            chk($sformatf("post_idx%0d", i), {30'b0, out_idx}, 32'(3 - i));
            $display("post-reset beat %0d: data=%04h idx=%0d", i, out_data, out_idx);
            tick();
        end
        chk("post_idle_valid", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
